// File: rtl/seg7_pkg.sv
// Register map, display mode encodings and controller FSM state type
// shared by the seven-segment display controller and its testbench.
package seg7_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_HOLD   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_DATA   = 2'd0;
  localparam logic [1:0] MODE_PC     = 2'd1;
  localparam logic [1:0] MODE_ROT    = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_rot_timer.sv
// Rotation page timer: toggles rot_sel every hold_i cycles while enabled.
// A zero hold stalls the page; clearing or disabling resets the count but keeps the page.
module seg7_rot_timer #(
  parameter int HOLD_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              rot_sel_o
);

  logic [HOLD_W-1:0] rot_cnt_q, rot_cnt_d;
  logic              rot_sel_q, rot_sel_d;

  always_comb begin
    rot_cnt_d = rot_cnt_q;
    rot_sel_d = rot_sel_q;
    if (clr_i || !en_i) begin
      rot_cnt_d = '0;
    end else if (hold_i != '0) begin
      if (rot_cnt_q == hold_i - 1'b1) begin
        rot_cnt_d = '0;
        rot_sel_d = ~rot_sel_q;
      end else begin
        rot_cnt_d = rot_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_cnt_q <= '0;
      rot_sel_q <= 1'b0;
    end else begin
      rot_cnt_q <= rot_cnt_d;
      rot_sel_q <= rot_sel_d;
    end
  end

  assign rot_sel_o = rot_sel_q;

endmodule

// File: rtl/seg7_disp_ctrl.sv
// CPU-mapped seven-segment display controller: picks DATA or debug PC (optionally rotating)
// and issues rate-limited one-cycle latch strobes with the chosen value.
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int                MIN_GAP      = 16,
  parameter int                HOLD_W       = 24,
  parameter logic [HOLD_W-1:0] HOLD_DEFAULT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic [31:0] dbg_pc,
  output logic [31:0] disp_data,
  output logic        disp_cs
);

  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        mode_q, mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              force_q, force_d;
  logic [31:0]       last_q, last_d;
  logic [31:0]       disp_data_q, disp_data_d;
  logic              disp_cs_q, disp_cs_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        wr_data, wr_ctrl, wr_hold;
  logic        rot_sel, pending, busy, send;
  logic [31:0] sel_val;

  assign wr_data = cpu_we && (cpu_addr == REG_DATA);
  assign wr_ctrl = cpu_we && (cpu_addr == REG_CTRL);
  assign wr_hold = cpu_we && (cpu_addr == REG_HOLD);

  seg7_rot_timer #(.HOLD_W(HOLD_W)) u_rot (
    .clk       (clk),
    .reset     (reset),
    .en_i      (mode_q == MODE_ROT),
    .clr_i     (wr_hold),
    .hold_i    (hold_q),
    .rot_sel_o (rot_sel)
  );

  always_comb begin
    case (mode_q)
      MODE_PC:  sel_val = dbg_pc;
      MODE_ROT: sel_val = rot_sel ? dbg_pc : data_q;
      default:  sel_val = data_q;
    endcase
  end

  assign pending = (mode_q != MODE_FREEZE) && ((sel_val != last_q) || force_q);
  assign busy    = (state_q != ST_IDLE);

  // The last GAP cycle doubles as IDLE so back-to-back strobes land exactly MIN_GAP apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    send    = 1'b0;
    case (state_q)
      ST_IDLE: if (pending) state_d = ST_SEND;
      ST_SEND: begin
        send    = 1'b1;
        state_d = ST_GAP;
        gap_d   = GAP_W'(MIN_GAP - 2);
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = pending ? ST_SEND : ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d      = wr_data ? cpu_wdata : data_q;
    mode_d      = wr_ctrl ? cpu_wdata[1:0] : mode_q;
    hold_d      = wr_hold ? cpu_wdata[HOLD_W-1:0] : hold_q;
    force_d     = force_q;
    if (send)                   force_d = 1'b0;
    if (wr_ctrl && cpu_wdata[2]) force_d = 1'b1;
    last_d      = send ? sel_val : last_q;
    disp_data_d = send ? sel_val : disp_data_q;
    disp_cs_d   = send;
    case (cpu_addr)
      REG_DATA: rdata_d = data_q;
      REG_CTRL: rdata_d = {30'b0, mode_q};
      REG_HOLD: rdata_d = 32'(hold_q);
      default:  rdata_d = {29'b0, busy, rot_sel, pending};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      data_q      <= '0;
      mode_q      <= MODE_DATA;
      hold_q      <= HOLD_DEFAULT;
      force_q     <= 1'b1;
      last_q      <= '0;
      disp_data_q <= '0;
      disp_cs_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      force_q     <= force_d;
      last_q      <= last_d;
      disp_data_q <= disp_data_d;
      disp_cs_q   <= disp_cs_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign disp_data = disp_data_q;
  assign disp_cs   = disp_cs_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Directed bench for seg7_disp_ctrl: expected strobes (cycle, value) are queued as stimulus
// is applied and matched against strobes captured from the display interface.
module tb_seg7_disp_ctrl;
  import seg7_pkg::*;

  localparam int MIN_GAP = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] dbg_pc = 32'd0;
  logic [31:0] cpu_rdata, disp_data;
  logic        disp_cs;

  typedef struct {
    int          t;
    logic [31:0] dat;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  wr_cyc;

  seg7_disp_ctrl #(
    .MIN_GAP      (MIN_GAP),
    .HOLD_W       (24),
    .HOLD_DEFAULT (24'hFFFFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .dbg_pc    (dbg_pc),
    .disp_data (disp_data),
    .disp_cs   (disp_cs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (disp_cs === 1'b1) obs_q.push_back('{cyc, disp_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk);
    #1 cpu_we = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    @(posedge clk);
    #1 cpu_addr = a;
    @(posedge clk);
    #1 v = cpu_rdata;
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_count"}, 32'(obs_q.size() >= n), 32'd1);
  endtask

  task automatic sb_pop(input string tag);
    ev_t e, o;
    check({tag, "_avail"}, 32'(obs_q.size() > 0 && exp_q.size() > 0), 32'd1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_data"}, o.dat, e.dat);
      check({tag, "_cycle"}, o.t, e.t);
    end
  endtask

  initial begin
    logic [31:0] v, prev;
    ev_t         o, o2;
    int          e0, pc, rel;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(disp_cs), 32'd0);
    check("rst_data", disp_data, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    exp_q.push_back('{rel + 2, 32'h0});
    wait_strobes("boot", 1, 10);
    sb_pop("boot");
    repeat (100) @(posedge clk);
    #1 check("boot_quiet", obs_q.size(), 32'd0);

    read_reg(REG_HOLD, v);   check("hold_rst", v, 32'h00FF_FFFF);
    read_reg(REG_STATUS, v); check("status_idle", v, 32'd0);
    read_reg(REG_CTRL, v);   check("ctrl_rst", v, 32'd0);

    // single DATA write
    wr(REG_DATA, 32'h1234ABCD);
    exp_q.push_back('{wr_cyc + 2, 32'h1234ABCD});
    wait_strobes("data", 1, 10);
    sb_pop("data");
    read_reg(REG_STATUS, v);
    check("pending_clr", 32'(v[0]), 32'd0);

    // DATA written every cycle for 40 cycles: strobes rate limited, latest value wins
    repeat (20) @(posedge clk);
    #1 cpu_we = 1'b1; cpu_addr = REG_DATA;
    e0 = 0;
    for (int i = 0; i < 40; i++) begin
      cpu_wdata = 32'hB000_0000 + 32'(i);
      @(posedge clk);
      #1;
      if (i == 0) e0 = cyc;
    end
    cpu_we = 1'b0;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{e0 + 2 + MIN_GAP * k,
                        32'hB000_0000 + 32'(((1 + MIN_GAP * k) > 39) ? 39 : (1 + MIN_GAP * k))});
    wait_strobes("burst", 4, 80);
    for (int k = 0; k < 4; k++) sb_pop("burst");
    repeat (40) @(posedge clk);
    #1 check("burst_quiet", obs_q.size(), 32'd0);

    // rotation between DATA=5 and PC=0x400
    dbg_pc = 32'h400;
    wr(REG_DATA, 32'd5);
    exp_q.push_back('{wr_cyc + 2, 32'd5});
    wait_strobes("rot_pre", 1, 10);
    sb_pop("rot_pre");
    repeat (20) @(posedge clk);
    wr(REG_HOLD, 32'd10);
    wr(REG_CTRL, 32'd2);
    wait_strobes("rot", 5, 200);
    prev = 32'd5;
    pc = 0;
    for (int i = 0; i < 5; i++) begin
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check("rot_alt", o.dat, (prev == 32'd5) ? 32'h400 : 32'd5);
        if (i > 0) check("rot_space", 32'((o.t - pc) >= MIN_GAP), 32'd1);
        prev = o.dat;
        pc = o.t;
      end
    end

    // long hold: strobes follow the page period exactly
    wr(REG_HOLD, 32'd40);
    repeat (60) @(posedge clk);
    #1 obs_q.delete();
    wait_strobes("rot40", 2, 120);
    if (obs_q.size() >= 2) begin
      o  = obs_q.pop_front();
      o2 = obs_q.pop_front();
      check("rot40_space", o2.t - o.t, 32'd40);
      check("rot40_alt", o2.dat ^ o.dat, 32'h405);
    end

    // freeze, then unfreeze and force
    wr(REG_CTRL, 32'd3);
    repeat (20) @(posedge clk);
    #1 obs_q.delete();
    wr(REG_DATA, 32'd7);
    repeat (40) @(posedge clk);
    #1 check("freeze_quiet", obs_q.size(), 32'd0);
    wr(REG_CTRL, 32'd0);
    exp_q.push_back('{wr_cyc + 2, 32'd7});
    wait_strobes("unfreeze", 1, 10);
    sb_pop("unfreeze");
    repeat (20) @(posedge clk);
    wr(REG_CTRL, 32'd4);
    exp_q.push_back('{wr_cyc + 2, 32'd7});
    wait_strobes("force", 1, 10);
    sb_pop("force");
    repeat (40) @(posedge clk);
    #1 check("force_once", obs_q.size(), 32'd0);
    read_reg(REG_CTRL, v);
    check("ctrl_force_rd0", v, 32'd0);

    // read in the same cycle as a write returns the old value
    wr(REG_DATA, 32'd9);
    check("rd_old", cpu_rdata, 32'd7);
    exp_q.push_back('{wr_cyc + 2, 32'd9});
    wait_strobes("rd_new", 1, 10);
    sb_pop("rd_new");

    // asynchronous reset while the strobe is up
    repeat (20) @(posedge clk);
    wr(REG_DATA, 32'hA5);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("gap_cs", 32'(disp_cs), 32'd1);
    check("gap_data", disp_data, 32'hA5);
    reset = 1'b1;
    #1;
    check("arst_cs", 32'(disp_cs), 32'd0);
    check("arst_data", disp_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    exp_q.push_back('{rel + 2, 32'h0});
    wait_strobes("post_rst", 1, 10);
    sb_pop("post_rst");
    read_reg(REG_DATA, v); check("post_rst_data", v, 32'd0);
    read_reg(REG_HOLD, v); check("post_rst_hold", v, 32'h00FF_FFFF);
    repeat (20) @(posedge clk);
    #1 check("end_quiet", obs_q.size(), 32'd0);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
